instr_sequencer: RTL and testbench

- Upstream instruction-issue stage for the vector processor.
- Holds a small program of 13-bit vector instructions, loaded through a write port.
- On start, drives each instruction onto the processor's `instruction` input for a fixed number of cycles, then moves to the next.
- Replaces hand-timed stimulus with a deterministic, cycle-exact issue stream.

---
 rtl/vproc_pkg.sv | 21 ++
 rtl/seq_prog_mem.sv | 26 ++
 rtl/instr_sequencer.sv | 152 +++++++++++++++
 tb/tb_instr_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vproc_pkg.sv
// Shared definitions for the vector processor front end:
// instruction field layout, opcodes and sequencer states.
package vproc_pkg;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_MUL   = 2'b11;

    localparam int OPC_HI  = 12;
    localparam int OPC_LO  = 11;
    localparam int REG_HI  = 10;
    localparam int REG_LO  = 9;
    localparam int ADDR_HI = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } seq_state_t;

endpackage

// File: rtl/seq_prog_mem.sv
// Program store for the instruction sequencer.
// Synchronous write, asynchronous read, contents not reset.
module seq_prog_mem #(
    parameter int DEPTH   = 16,
    parameter int INSTR_W = 13,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [INSTR_W-1:0] rd_data
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_sequencer.sv
// Issues a stored program to the vector processor, one instruction per
// HOLD_CYCLES window. Define SEQ_LOOP_EN to repeat the program until halt.
module instr_sequencer
    import vproc_pkg::*;
#(
    parameter int INSTR_W     = 13,
    parameter int DEPTH       = 16,
    parameter int HOLD_CYCLES = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [INSTR_W-1:0]       prog_data,
    input  logic [$clog2(DEPTH):0]   prog_len,
    input  logic                     start,
    input  logic                     halt,
    output logic [INSTR_W-1:0]       instruction,
    output logic                     issue_valid,
    output logic                     issue_strobe,
    output logic [$clog2(DEPTH)-1:0] pc,
    output logic                     busy,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [HW-1:0] HOLD_RLD = HW'(HOLD_CYCLES - 1);
    localparam logic [LW-1:0] LEN_MAX  = LW'(DEPTH);

    seq_state_t state_q, state_d;

    logic [AW-1:0]      pc_q, pc_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [LW-1:0]      len_q, len_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               strobe_q, strobe_d;
    logic               done_q, done_d;

    logic               mem_we;
    logic [AW-1:0]      rd_addr;
    logic [INSTR_W-1:0] rd_data;
    logic [INSTR_W-1:0] issue_word;
    logic [1:0]         opc;
    logic               expire;
    logic               last;

    assign mem_we = prog_we && (state_q == IDLE);

    seq_prog_mem #(
        .DEPTH   (DEPTH),
        .INSTR_W (INSTR_W)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign expire = (hold_q == '0);
    assign last   = ({1'b0, pc_q} + LW'(1)) >= len_q;

    // The read port always points at whatever would be issued next.
    assign rd_addr = (state_q == ISSUE && !last) ? pc_q + AW'(1) : '0;

    // Arithmetic ops carry no operands, so their operand bits are forced low.
    assign opc = rd_data[OPC_HI:OPC_LO];
    assign issue_word = (opc == OP_ADD || opc == OP_MUL)
                      ? {opc, {(INSTR_W-2){1'b0}}}
                      : rd_data;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        hold_d   = hold_q;
        len_d    = len_q;
        instr_d  = instr_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !halt) begin
                    if (prog_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = ISSUE;
                        len_d    = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
                        pc_d     = '0;
                        hold_d   = HOLD_RLD;
                        instr_d  = issue_word;
                        strobe_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (halt) begin
                    state_d = IDLE;
                end else if (!expire) begin
                    hold_d = hold_q - HW'(1);
                end else if (!last) begin
                    pc_d     = pc_q + AW'(1);
                    hold_d   = HOLD_RLD;
                    instr_d  = issue_word;
                    strobe_d = 1'b1;
                end else begin
                    done_d = 1'b1;
`ifdef SEQ_LOOP_EN
                    pc_d     = '0;
                    hold_d   = HOLD_RLD;
                    instr_d  = issue_word;
                    strobe_d = 1'b1;
`else
                    state_d  = IDLE;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            hold_q   <= '0;
            len_q    <= '0;
            instr_q  <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            hold_q   <= hold_d;
            len_q    <= len_d;
            instr_q  <= instr_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
    end

    assign instruction  = instr_q;
    assign issue_valid  = (state_q == ISSUE);
    assign issue_strobe = strobe_q;
    assign pc           = pc_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed tables and sequences
// plus randomized traffic against a schedule-based reference model.
module tb_instr_sequencer;

    localparam int H = 10;
    localparam int D = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [12:0] prog_data;
    logic [4:0]  prog_len;
    logic        start;
    logic        halt;
    logic [12:0] instruction;
    logic        issue_valid;
    logic        issue_strobe;
    logic [3:0]  pc;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .prog_len     (prog_len),
        .start        (start),
        .halt         (halt),
        .instruction  (instruction),
        .issue_valid  (issue_valid),
        .issue_strobe (issue_strobe),
        .pc           (pc),
        .busy         (busy),
        .done         (done)
    );

    // Reference: a run is a timeline of len*H cycles; position k on that
    // timeline gives the slot k/H and whether this is a slot's first cycle.
    logic [12:0] m_mem [D];
    bit          m_run;
    int          m_k;
    int          m_len;
    int          m_pc;
    logic [12:0] m_instr;
    bit          m_done;

    function automatic logic [12:0] masked(logic [12:0] w);
        return w[12] ? {w[12:11], 11'b0} : w;
    endfunction

    task automatic model_edge();
        bit idle0;
        idle0  = !m_run;
        m_done = 1'b0;
        if (rst) begin
            m_run   = 1'b0;
            m_k     = 0;
            m_len   = 0;
            m_pc    = 0;
            m_instr = '0;
        end else if (m_run) begin
            if (halt) begin
                m_run = 1'b0;
            end else begin
                m_k++;
                if (m_k == m_len * H) begin
                    m_done = 1'b1;
`ifdef SEQ_LOOP_EN
                    m_k = 0;
`else
                    m_run = 1'b0;
`endif
                end
            end
        end else if (start && !halt) begin
            if (prog_len == 0) begin
                m_done = 1'b1;
            end else begin
                m_run = 1'b1;
                m_k   = 0;
                m_len = (prog_len > D) ? D : int'(prog_len);
            end
        end
        if (m_run) begin
            m_pc    = m_k / H;
            m_instr = masked(m_mem[m_pc]);
        end
        if (idle0 && prog_we) begin
            m_mem[prog_addr] = prog_data;
        end
    endtask

    task automatic cyc();
        logic exp_s;
        model_edge();
        @(posedge clk);
        #2;
        exp_s = m_run && (m_k % H == 0);
        checks++;
        if ({instruction, issue_valid, issue_strobe, pc, busy, done} !==
            {m_instr, m_run, exp_s, 4'(m_pc), m_run, m_done}) begin
            errors++;
            $display("FAIL model t=%0t got instr=%h v=%b s=%b pc=%0d busy=%b done=%b exp instr=%h v=%b s=%b pc=%0d busy=%b done=%b",
                     $time, instruction, issue_valid, issue_strobe, pc, busy, done,
                     m_instr, m_run, exp_s, m_pc, m_run, m_done);
        end
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic load(int a, logic [12:0] d);
        prog_we   = 1'b1;
        prog_addr = 4'(a);
        prog_data = d;
        cyc();
        prog_we = 1'b0;
    endtask

    typedef struct {
        int          cyc;
        logic [12:0] instr;
        logic        strobe;
        int          pc;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tab [11];
    logic [12:0] prog [4];

    initial begin
        int strobes;
        int dseen;

        tab[0]  = '{1,  13'h0000, 1'b1, 0, 1'b1, 1'b0};
        tab[1]  = '{2,  13'h0000, 1'b0, 0, 1'b1, 1'b0};
        tab[2]  = '{10, 13'h0000, 1'b0, 0, 1'b1, 1'b0};
        tab[3]  = '{11, 13'h0200, 1'b1, 1, 1'b1, 1'b0};
        tab[4]  = '{20, 13'h0200, 1'b0, 1, 1'b1, 1'b0};
        tab[5]  = '{21, 13'h1000, 1'b1, 2, 1'b1, 1'b0};
        tab[6]  = '{30, 13'h1000, 1'b0, 2, 1'b1, 1'b0};
        tab[7]  = '{31, 13'h1800, 1'b1, 3, 1'b1, 1'b0};
        tab[8]  = '{40, 13'h1800, 1'b0, 3, 1'b1, 1'b0};
`ifdef SEQ_LOOP_EN
        tab[9]  = '{41, 13'h0000, 1'b1, 0, 1'b1, 1'b1};
        tab[10] = '{42, 13'h0000, 1'b0, 0, 1'b1, 1'b0};
`else
        tab[9]  = '{41, 13'h1800, 1'b0, 3, 1'b0, 1'b1};
        tab[10] = '{42, 13'h1800, 1'b0, 3, 1'b0, 1'b0};
`endif
        prog[0] = 13'h0000;
        prog[1] = 13'h0200;
        prog[2] = 13'h17FF;
        prog[3] = 13'h1800;

        rst = 1'b1; prog_we = 1'b0; start = 1'b0; halt = 1'b0;
        prog_addr = '0; prog_data = '0; prog_len = '0;
        m_run = 1'b0; m_k = 0; m_len = 0; m_pc = 0; m_instr = '0; m_done = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("idle_instr", 32'(instruction), 32'h0);
            chk("idle_busy", 32'(busy), 32'h0);
            chk("idle_done", 32'(done), 32'h0);
            chk("idle_pc", 32'(pc), 32'h0);
        end

        for (int i = 0; i < D; i++) begin
            load(i, (i < 4) ? prog[i] : 13'($urandom));
        end

        // Main run, with a write attempt to entry 3 while issuing.
        prog_len = 5'd4;
        start    = 1'b1;
        for (int c = 1; c <= 42; c++) begin
            cyc();
            start   = 1'b0;
            prog_we = 1'b0;
            if (c == 25) begin
                prog_we   = 1'b1;
                prog_addr = 4'd3;
                prog_data = 13'h0E00;
            end
            foreach (tab[j]) begin
                if (tab[j].cyc == c) begin
                    chk("tab_instr", 32'(instruction), 32'(tab[j].instr));
                    chk("tab_strobe", 32'(issue_strobe), 32'(tab[j].strobe));
                    chk("tab_pc", 32'(pc), 32'(tab[j].pc));
                    chk("tab_busy", 32'(busy), 32'(tab[j].busy));
                    chk("tab_done", 32'(done), 32'(tab[j].done));
                end
            end
        end
        halt = 1'b1;
        cyc();
        halt = 1'b0;
        cyc();

        // Halt during the second slot.
        prog_len = 5'd4;
        start    = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            cyc();
            start = 1'b0;
            if (c == 15) halt = 1'b1;
            if (c == 16) begin
                halt = 1'b0;
                chk("halt_busy", 32'(busy), 32'h0);
                chk("halt_valid", 32'(issue_valid), 32'h0);
                chk("halt_instr", 32'(instruction), 32'h0200);
            end
            if (c >= 16) chk("halt_no_done", 32'(done), 32'h0);
        end

        // Empty program.
        prog_len = 5'd0;
        start    = 1'b1;
        cyc();
        start = 1'b0;
        chk("empty_done", 32'(done), 32'h1);
        chk("empty_busy", 32'(busy), 32'h0);
        chk("empty_instr", 32'(instruction), 32'h0200);
        cyc();
        chk("empty_done2", 32'(done), 32'h0);
        chk("empty_busy2", 32'(busy), 32'h0);

        // Length clamp: 20 requested, 16 issued.
        prog_len = 5'd20;
        start    = 1'b1;
        strobes  = 0;
        dseen    = -1;
        for (int c = 1; c <= 161; c++) begin
            cyc();
            start = 1'b0;
            if (c <= 160 && issue_strobe) strobes++;
            if (done && dseen < 0) dseen = c;
        end
        chk("clamp_strobes", 32'(strobes), 32'd16);
        chk("clamp_done_cycle", 32'(dseen), 32'd161);
        halt = 1'b1;
        cyc();
        halt = 1'b0;
        cyc();

        // Reset in the middle of a run.
        prog_len = 5'd4;
        start    = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            start = 1'b0;
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_instr", 32'(instruction), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_strobe", 32'(issue_strobe), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            prog_we   = ($urandom_range(0, 3) == 0);
            prog_addr = 4'($urandom);
            prog_data = 13'($urandom);
            start     = ($urandom_range(0, 7) == 0);
            halt      = ($urandom_range(0, 150) == 0);
            prog_len  = 5'($urandom_range(0, 20));
            rst       = ($urandom_range(0, 999) == 0);
            cyc();
        end
        prog_we = 1'b0;
        start   = 1'b0;
        halt    = 1'b0;
        rst     = 1'b0;
        for (int i = 0; i < 5; i++) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
